// File: rtl/charmatrix_refresh_sequencer_if.sv
// Pixel stream from the refresh sequencer to the ws2812b driver.
// One pixel moves on pix_valid & pix_ready.
interface charmatrix_refresh_sequencer_if;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_last;
  logic [7:0] char_index;
  logic [3:0] color_index;
  logic [5:0] led_in_char;

  modport master (
    output pix_valid, pix_last,
    output char_index, color_index,
    output led_in_char,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_last,
    input  char_index, color_index,
    input  led_in_char,
    output pix_ready
  );
endinterface

// File: rtl/charmatrix_refresh_sequencer.sv
// Frame scheduler for the char-matrix LED strip: walks buffer cells, streams pixels.
// Optional CHARMATRIX_SEQ_AUTOSCROLL_EN replaces base_char with an internal scroll.
module charmatrix_refresh_sequencer #(
  parameter int MAX_CHARS      = 8,
  parameter int CHAR_LEDS      = 35,
  parameter int FRAME_DIV_BITS = 18,
  localparam int AW            = $clog2(MAX_CHARS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] last_char,
  input  logic [8:0]    last_led,
  input  logic [AW-1:0] base_char,
  input  logic          refresh_req,
  output logic          buf_rd_en,
  output logic [AW-1:0] buf_rd_addr,
  input  logic [7:0]    buf_char,
  input  logic [3:0]    buf_color,
  charmatrix_refresh_sequencer_if.master px,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, DONE
  } state_t;

  state_t state_q, state_d;

  logic [FRAME_DIV_BITS-1:0] div_q;
  logic          pend_q, pend_d;
  logic [AW-1:0] lc_q;
  logic [8:0]    ll_q;
  logic [AW-1:0] slot_q;
  logic [5:0]    lic_q;
  logic [8:0]    cnt_q;
  logic [7:0]    chr_q;
  logic [3:0]    col_q;

  logic          start, go, pv, xfer;
  logic          last_px, cell_end;
  logic [AW-1:0] slot_nx, base_src, base_eff;

  assign start    = (&div_q) | refresh_req;
  assign xfer     = pv & px.pix_ready;
  assign last_px  = (cnt_q == ll_q);
  assign cell_end = (lic_q == 6'(CHAR_LEDS - 1));
  assign slot_nx  = (slot_q == lc_q) ? '0 : AW'(slot_q + 1'b1);

`ifdef CHARMATRIX_SEQ_AUTOSCROLL_EN
  logic [5:0]    fcnt_q;
  logic [AW-1:0] scr_q, scr_nx;
  logic          scr_step;

  assign scr_nx   = (scr_q == lc_q) ? '0 : AW'(scr_q + 1'b1);
  assign scr_step = (state_q == DONE) & (&fcnt_q);
  // a frame chained from DONE must see the scroll step of the frame just ended
  assign base_src = scr_step ? scr_nx : scr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      scr_q  <= '0;
    end else if (state_q == DONE) begin
      fcnt_q <= fcnt_q + 6'd1;
      if (scr_step) scr_q <= scr_nx;
    end
  end
`else
  assign base_src = base_char;
`endif

  assign base_eff = (base_src > last_char) ? '0 : base_src;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    go         = 1'b0;
    pv         = 1'b0;
    buf_rd_en  = 1'b0;
    frame_done = 1'b0;
    overrun    = 1'b0;
    unique case (state_q)
      IDLE:  go = start;
      FETCH: begin
        buf_rd_en = 1'b1;
        state_d   = LOAD;
      end
      LOAD:  state_d = SEND;
      SEND: begin
        pv = 1'b1;
        if (xfer) begin
          if (last_px)       state_d = DONE;
          else if (cell_end) state_d = FETCH;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
        go         = pend_q | start;
        pend_d     = pend_q & start;
      end
      default: state_d = IDLE;
    endcase
    if (go) state_d = FETCH;
    if (start && (state_q inside {FETCH, LOAD, SEND})) begin
      if (pend_q) overrun = 1'b1;
      else        pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      div_q   <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc_q   <= '0;
      ll_q   <= '0;
      slot_q <= '0;
      lic_q  <= '0;
      cnt_q  <= '0;
      chr_q  <= '0;
      col_q  <= '0;
    end else if (go) begin
      lc_q   <= last_char;
      ll_q   <= last_led;
      slot_q <= base_eff;
      lic_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == LOAD) begin
      chr_q <= buf_char;
      col_q <= buf_color;
    end else if (xfer) begin
      cnt_q <= cnt_q + 9'd1;
      if (cell_end) begin
        lic_q  <= '0;
        slot_q <= slot_nx;
      end else begin
        lic_q <= lic_q + 6'd1;
      end
    end
  end

  assign buf_rd_addr    = buf_rd_en ? slot_q : '0;
  assign busy           = (state_q != IDLE);
  assign px.pix_valid   = pv;
  assign px.pix_last    = pv & last_px;
  assign px.char_index  = chr_q;
  assign px.color_index = col_q;
  assign px.led_in_char = lic_q;

endmodule
